// File: rtl/ball_step_scheduler.sv
// ----------------------------------------------------------------------------
// ball_step_scheduler
//
// Per-frame ball sequencer for breakout. On every accepted frame_tick it
// computes the candidate next position, resolves screen-edge and paddle
// bounces, looks up the brick under the candidate position through a req/ack
// port to the brick-state store, and then either commits the move, flips the
// vertical direction and clears the hit brick, or enters LOST.
//
// Optional feature (compile-time macro BALL_STEP_OVERRUN_EN):
//   When defined, adds output overrun_cnt[7:0] counting frame_ticks dropped
//   while busy (saturating at 255, cleared by reset and by an honoured launch).
//   When undefined the port and counter do not exist.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   frame_tick           one-cycle pulse per frame; dropped while busy
//   launch               serve request, honoured in SERVE/LOST only
//   xstep, ystep [6:0]   per-frame step (px), sampled with frame_tick
//   paddle_x [9:0]       paddle left edge
//   brk_req / brk_num    brick lookup request and index (4*row+col)
//   brk_ack / brk_alive  lookup response
//   brk_clr              one-cycle pulse: clear brick brk_num
//   ball_x, ball_y       ball position
//   dir [1:0]            [0]: 0=+X 1=-X, [1]: 0=+Y(down) 1=-Y
//   busy                 high in EDGE/BRKREQ/COMMIT
//   hit_pulse            one-cycle pulse on brick or paddle hit
//   lost                 high in LOST
//
// Brick handshake: brk_req rises when a lookup is needed and stays high, with
// brk_num stable, up to and including the cycle in which brk_ack is sampled
// high; brk_alive is only meaningful in that cycle. brk_req drops on the
// following cycle. Ack latency may be any number of cycles >= 1.
// ----------------------------------------------------------------------------
module ball_step_scheduler #(
    parameter int SCR_W    = 640,
    parameter int SCR_H    = 480,
    parameter int BALL_X0  = 320,
    parameter int BALL_Y0  = 400,
    parameter int PADDLE_Y = 440,
    parameter int PADDLE_W = 80
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame_tick,
    input  logic       launch,
    input  logic [6:0] xstep,
    input  logic [6:0] ystep,
    input  logic [9:0] paddle_x,
    output logic       brk_req,
    output logic [3:0] brk_num,
    input  logic       brk_ack,
    input  logic       brk_alive,
    output logic       brk_clr,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] dir,
    output logic       busy,
    output logic       hit_pulse,
    output logic       lost
`ifdef BALL_STEP_OVERRUN_EN
    ,
    output logic [7:0] overrun_cnt
`endif
);

    typedef enum logic [2:0] {
        S_SERVE  = 3'd0,
        S_IDLE   = 3'd1,
        S_EDGE   = 3'd2,
        S_BRKREQ = 3'd3,
        S_COMMIT = 3'd4,
        S_LOST   = 3'd5
    } state_t;

    // 11-bit arithmetic keeps x+step and x-step (wrapped) unambiguous.
    localparam logic [10:0] X_LIMIT  = 11'(SCR_W - 1);
    localparam logic [10:0] Y_LIMIT  = 11'(SCR_H - 1);
    localparam logic [10:0] PAD_Y    = 11'(PADDLE_Y);
    localparam logic [10:0] PAD_W    = 11'(PADDLE_W);

    // Brick grid: column c covers X 20+140c..140+140c, row r covers Y 20+60r..60+60r.
    localparam int BRK_X_ORG = 20;
    localparam int BRK_X_LEN = 120;
    localparam int BRK_X_PIT = 140;
    localparam int BRK_Y_ORG = 20;
    localparam int BRK_Y_LEN = 40;
    localparam int BRK_Y_PIT = 60;

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [1:0]  dir_q, dir_d;
    logic [10:0] nx_q, nx_d;
    logic [10:0] ny_q, ny_d;
    logic [6:0]  xs_q, xs_d;
    logic [6:0]  ys_q, ys_d;
    logic [3:0]  num_q, num_d;
    logic        clr_q, clr_d;
    logic        hit_q, hit_d;

    // Collision terms, all derived from registered values during EDGE.
    logic        x_edge, y_top, pad_hit, bottom;
    logic        col_hit, row_hit;
    logic [1:0]  col_idx, row_idx;

    always_comb begin
        x_edge  = dir_q[0] ? ({4'b0, xs_q} > {1'b0, x_q})
                           : (({1'b0, x_q} + {4'b0, xs_q}) >= X_LIMIT);
        y_top   = dir_q[1] && ({1'b0, y_q} < {4'b0, ys_q});
        pad_hit = !dir_q[1] && ({1'b0, y_q} < PAD_Y) && (ny_q >= PAD_Y) &&
                  (nx_q >= {1'b0, paddle_x}) && (nx_q <= ({1'b0, paddle_x} + PAD_W));
        bottom  = !dir_q[1] && (ny_q >= Y_LIMIT) && !pad_hit;
    end

    always_comb begin
        col_hit = 1'b0;
        col_idx = 2'd0;
        row_hit = 1'b0;
        row_idx = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (nx_q >= 11'(BRK_X_ORG + BRK_X_PIT * c) &&
                nx_q <= 11'(BRK_X_ORG + BRK_X_PIT * c + BRK_X_LEN)) begin
                col_hit = 1'b1;
                col_idx = 2'(c);
            end
        end
        for (int r = 0; r < 3; r++) begin
            if (ny_q >= 11'(BRK_Y_ORG + BRK_Y_PIT * r) &&
                ny_q <= 11'(BRK_Y_ORG + BRK_Y_PIT * r + BRK_Y_LEN)) begin
                row_hit = 1'b1;
                row_idx = 2'(r);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        num_d   = num_q;
        clr_d   = 1'b0;
        hit_d   = 1'b0;

        case (state_q)
            S_SERVE, S_LOST: begin
                if (launch) begin
                    x_d     = 10'(BALL_X0);
                    y_d     = 10'(BALL_Y0);
                    dir_d   = 2'b11;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (frame_tick) begin
                    xs_d    = xstep;
                    ys_d    = ystep;
                    nx_d    = dir_q[0] ? ({1'b0, x_q} - {4'b0, xstep}) : ({1'b0, x_q} + {4'b0, xstep});
                    ny_d    = dir_q[1] ? ({1'b0, y_q} - {4'b0, ystep}) : ({1'b0, y_q} + {4'b0, ystep});
                    state_d = S_EDGE;
                end
            end
            S_EDGE: begin
                if (bottom) begin
                    state_d = S_LOST;
                end else if (x_edge || y_top || pad_hit) begin
                    // Bounce in place: flip the offending axis, keep position.
                    dir_d[0] = dir_q[0] ^ x_edge;
                    dir_d[1] = dir_q[1] ^ (y_top | pad_hit);
                    hit_d    = pad_hit;
                    state_d  = S_IDLE;
                end else if (col_hit && row_hit) begin
                    num_d   = {row_idx, col_idx};
                    state_d = S_BRKREQ;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_BRKREQ: begin
                if (brk_ack) begin
                    if (brk_alive) begin
                        clr_d    = 1'b1;
                        hit_d    = 1'b1;
                        dir_d[1] = ~dir_q[1];
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                x_d     = nx_q[9:0];
                y_d     = ny_q[9:0];
                state_d = S_IDLE;
            end
            default: state_d = S_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_SERVE;
            x_q     <= 10'(BALL_X0);
            y_q     <= 10'(BALL_Y0);
            dir_q   <= 2'b11;
            nx_q    <= '0;
            ny_q    <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            num_q   <= '0;
            clr_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            num_q   <= num_d;
            clr_q   <= clr_d;
            hit_q   <= hit_d;
        end
    end

`ifdef BALL_STEP_OVERRUN_EN
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if ((state_q == S_SERVE || state_q == S_LOST) && launch) begin
            ovr_d = 8'd0;
        end else if (busy && frame_tick && ovr_q != 8'hFF) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovr_q <= 8'd0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_cnt = ovr_q;
`endif

    assign brk_req   = (state_q == S_BRKREQ);
    assign brk_num   = num_q;
    assign brk_clr   = clr_q;
    assign hit_pulse = hit_q;
    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign dir       = dir_q;
    assign busy      = (state_q == S_EDGE) || (state_q == S_BRKREQ) || (state_q == S_COMMIT);
    assign lost      = (state_q == S_LOST);

endmodule

// File: tb/tb_ball_step_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ball_step_scheduler
//
// Drives frame steps, launches and brick-store responses; a reference model
// predicts the outcome of each step from the game rules and pushes it into an
// expected queue. A monitor pops one entry whenever the DUT finishes a step
// (busy falls) and compares position, direction, lost, pulses and lookup.
// ----------------------------------------------------------------------------
module tb_ball_step_scheduler;

    localparam int W = 30;  // {x10, y10, dir2, lost, hit, clr, req, num4}

    logic       clk;
    logic       resetn;
    logic       frame_tick;
    logic       launch;
    logic [6:0] xstep;
    logic [6:0] ystep;
    logic [9:0] paddle_x;
    logic       brk_req;
    logic [3:0] brk_num;
    logic       brk_ack;
    logic       brk_alive;
    logic       brk_clr;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [1:0] dir;
    logic       busy;
    logic       hit_pulse;
    logic       lost;
`ifdef BALL_STEP_OVERRUN_EN
    logic [7:0] overrun_cnt;
`endif

    ball_step_scheduler dut (
        .clk        (clk),
        .resetn     (resetn),
        .frame_tick (frame_tick),
        .launch     (launch),
        .xstep      (xstep),
        .ystep      (ystep),
        .paddle_x   (paddle_x),
        .brk_req    (brk_req),
        .brk_num    (brk_num),
        .brk_ack    (brk_ack),
        .brk_alive  (brk_alive),
        .brk_clr    (brk_clr),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .dir        (dir),
        .busy       (busy),
        .hit_pulse  (hit_pulse),
        .lost       (lost)
`ifdef BALL_STEP_OVERRUN_EN
        ,
        .overrun_cnt(overrun_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] exp_q[$];
    int           resp_cnt = 0;
    logic         req_seen = 1'b0;
    logic [3:0]   num_seen = 4'd0;
    logic         busy_seen = 1'b0;
    logic         next_alive = 1'b0;
    int           ack_delay = 1;

    // reference model state
    int   m_x, m_y, m_ovr;
    logic m_d0, m_d1, m_lost;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic brick_at(input int nx, input int ny, output logic found, output int num);
        int c, r;
        found = 1'b0;
        num   = 0;
        if (nx >= 20 && ny >= 20) begin
            c = (nx - 20) / 140;
            r = (ny - 20) / 60;
            if (c < 4 && r < 3 && ((nx - 20) % 140) <= 120 && ((ny - 20) % 60) <= 40) begin
                found = 1'b1;
                num   = 4 * r + c;
            end
        end
    endtask

    task automatic model_eval(input int xs, input int ys, input int px, input logic alive,
                              output int ox, output int oy, output logic od0, output logic od1,
                              output logic olost, output logic [W-1:0] e);
        int   nx, ny, num;
        logic xe, yt, pd, bt, found, hit, clr, req;
        ox = m_x; oy = m_y; od0 = m_d0; od1 = m_d1; olost = m_lost;
        hit = 1'b0; clr = 1'b0; req = 1'b0; num = 0;
        nx = m_d0 ? m_x - xs : m_x + xs;
        ny = m_d1 ? m_y - ys : m_y + ys;
        xe = (!m_d0 && m_x + xs >= 639) || (m_d0 && m_x < xs);
        yt = m_d1 && m_y < ys;
        pd = !m_d1 && m_y < 440 && ny >= 440 && nx >= px && nx <= px + 80;
        bt = !m_d1 && ny >= 479 && !pd;
        if (bt) begin
            olost = 1'b1;
        end else if (xe || yt || pd) begin
            if (xe) od0 = !m_d0;
            if (yt || pd) od1 = !m_d1;
            hit = pd;
        end else begin
            brick_at(nx, ny, found, num);
            if (found) begin
                req = 1'b1;
                if (alive) begin
                    od1 = !m_d1;
                    hit = 1'b1;
                    clr = 1'b1;
                end else begin
                    ox = nx; oy = ny;
                end
            end else begin
                ox = nx; oy = ny;
            end
        end
        e = {10'(ox), 10'(oy), od1, od0, olost, hit, clr, req, 4'(num)};
    endtask

    // ---------------- brick-store responder ----------------
    initial begin
        brk_ack   = 1'b0;
        brk_alive = 1'b0;
        forever begin
            @(posedge clk); #1;
            brk_ack   = 1'b0;
            brk_alive = 1'b0;
            if (brk_req) begin
                req_seen = 1'b1;
                num_seen = brk_num;
                repeat (ack_delay - 1) begin
                    @(posedge clk); #1;
                end
                brk_ack   = 1'b1;
                brk_alive = next_alive;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic         prev_busy;
        logic         pulse_chk;
        logic [W-1:0] e, got;
        prev_busy = 1'b0;
        pulse_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (pulse_chk) begin
                check("hit_pulse_width", int'(hit_pulse), 0);
                check("brk_clr_width", int'(brk_clr), 0);
                pulse_chk = 1'b0;
            end
            if (prev_busy && !busy) begin
                got = {ball_x, ball_y, dir, lost, hit_pulse, brk_clr, req_seen, num_seen};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL step_unexpected got=%h expected=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL step got x=%0d y=%0d dir=%b lost=%b hit=%b clr=%b req=%b num=%0d expected x=%0d y=%0d dir=%b lost=%b hit=%b clr=%b req=%b num=%0d",
                                 got[29:20], got[19:10], got[9:8], got[7], got[6], got[5], got[4], got[3:0],
                                 e[29:20], e[19:10], e[9:8], e[7], e[6], e[5], e[4], e[3:0]);
                    end
                end
                if (hit_pulse || brk_clr) pulse_chk = 1'b1;
                resp_cnt++;
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_step(input int xs, input int ys, input int px, input logic alive,
                           input int dly, input int ndrop, input bit chk_lat);
        logic [W-1:0] e;
        int   n0, ox, oy, old_x;
        logic nd0, nd1, nl;
        model_eval(xs, ys, px, alive, ox, oy, nd0, nd1, nl, e);
        old_x      = m_x;
        xstep      = 7'(xs);
        ystep      = 7'(ys);
        paddle_x   = 10'(px);
        next_alive = alive;
        ack_delay  = dly;
        req_seen   = 1'b0;
        num_seen   = 4'd0;
        exp_q.push_back(e);
        n0 = resp_cnt;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        if (chk_lat) begin
            check("latency_c0_x", int'(ball_x), old_x);
            @(posedge clk); #1;
            check("latency_c1_x", int'(ball_x), old_x);
            @(posedge clk); #1;
            check("latency_c2_x", int'(ball_x), ox);
        end
        if (e[4] && ndrop > 0) begin
            for (int i = 0; i < ndrop; i++) begin
                @(posedge clk); #1 frame_tick = 1'b1;
                @(posedge clk); #1 frame_tick = 1'b0;
            end
            m_ovr = (m_ovr + ndrop > 255) ? 255 : m_ovr + ndrop;
        end
        for (int i = 0; i < 3000; i++) begin
            if (resp_cnt != n0) break;
            @(posedge clk);
        end
        if (resp_cnt == n0) begin
            checks++;
            errors++;
            $display("FAIL step_timeout got=no_done expected=done");
            exp_q.delete();
        end
        m_x = ox; m_y = oy; m_d0 = nd0; m_d1 = nd1; m_lost = nl;
`ifdef BALL_STEP_OVERRUN_EN
        #1 check("overrun_cnt", int'(overrun_cnt), m_ovr);
`endif
    endtask

    task automatic tick_ignored(input string name);
        int n0;
        n0 = resp_cnt;
        busy_seen = 1'b0;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check({name, "_busy"}, int'(busy_seen), 0);
        check({name, "_x"}, int'(ball_x), m_x);
        check({name, "_y"}, int'(ball_y), m_y);
        check({name, "_done"}, resp_cnt, n0);
    endtask

    task automatic launch_ball();
        @(posedge clk); #1 launch = 1'b1;
        @(posedge clk); #1 launch = 1'b0;
        m_x = 320; m_y = 400; m_d0 = 1'b1; m_d1 = 1'b1; m_lost = 1'b0; m_ovr = 0;
        check("launch_x", int'(ball_x), 320);
        check("launch_y", int'(ball_y), 400);
        check("launch_dir", int'(dir), 3);
        check("launch_lost", int'(lost), 0);
`ifdef BALL_STEP_OVERRUN_EN
        check("launch_overrun", int'(overrun_cnt), 0);
`endif
    endtask

    // Walk straight up with ystep=4 until n lookups have happened.
    task automatic approach_bricks(input int n, input logic alive_last, input int dly_last, input int drop_last);
        logic [W-1:0] e;
        int   ox, oy, nreq;
        logic a, b, c;
        nreq = 0;
        for (int i = 0; i < 200 && nreq < n; i++) begin
            model_eval(0, 4, 0, 1'b0, ox, oy, a, b, c, e);
            if (e[4]) begin
                nreq++;
                if (nreq == n) do_step(0, 4, 0, alive_last, dly_last, drop_last, 1'b0);
                else do_step(0, 4, 0, 1'b0, 3, 0, 1'b0);
            end else begin
                do_step(0, 4, 0, 1'b0, 1, 0, 1'b0);
            end
        end
        check("brick_lookups_reached", nreq, n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int flips, xs, ys, px;
        logic old_d0;
        resetn = 1'b0; frame_tick = 1'b0; launch = 1'b0;
        xstep = 7'd0; ystep = 7'd0; paddle_x = 10'd0;
        m_x = 320; m_y = 400; m_d0 = 1'b1; m_d1 = 1'b1; m_lost = 1'b0; m_ovr = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_x", int'(ball_x), 320);
        check("reset_y", int'(ball_y), 400);
        check("reset_dir", int'(dir), 3);
        check("reset_busy", int'(busy), 0);
        check("reset_lost", int'(lost), 0);
        check("reset_brk_req", int'(brk_req), 0);
        check("reset_hit", int'(hit_pulse), 0);
        check("reset_clr", int'(brk_clr), 0);
        @(negedge clk) resetn = 1'b1;

        tick_ignored("serve_tick");
        launch_ball();

        // first step with exact latency check: (320,400) -> (316,396)
        do_step(4, 4, 0, 1'b0, 1, 0, 1'b1);

        // brick 10: first lookup dead (commit), second alive with one dropped tick
        approach_bricks(1, 1'b0, 3, 0);
        approach_bricks(1, 1'b1, 10, 1);
        check("after_brick_dir", int'(dir), 1);

        // descend past the paddle into the bottom edge
        for (int i = 0; i < 200 && !m_lost; i++) do_step(0, 4, 0, 1'b0, 2, 0, 1'b0);
        check("lost_flag", int'(lost), 1);
        tick_ignored("lost_tick");
        launch_ball();

        // long lookup with 300 dropped ticks
        approach_bricks(1, 1'b0, 610, 300);

        // bounce off left then right edge
        flips = 0;
        for (int i = 0; i < 400 && flips < 2; i++) begin
            old_d0 = m_d0;
            do_step(4, 0, 0, 1'b0, 1, 0, 1'b0);
            if (m_d0 != old_d0) flips++;
        end
        check("x_bounces", flips, 2);

        // randomized play
        for (int i = 0; i < 300; i++) begin
            if (m_lost) begin
                if ($urandom_range(0, 1) == 1) tick_ignored("rand_lost_tick");
                launch_ball();
            end else begin
                xs = int'($urandom_range(0, 12));
                ys = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 12));
                if ($urandom_range(0, 1) == 1) px = m_x - 40 + int'($urandom_range(0, 40)) - 20;
                else px = int'($urandom_range(0, 559));
                if (px < 0) px = 0;
                if (px > 559) px = 559;
                do_step(xs, ys, px, 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 0, 1'b0);
            end
        end

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #600us;
        $display("FAIL watchdog got=running expected=finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
